x_400_mod_503_seq: RTL and testbench

//  Sequential reducer computing R = X mod 503 for an N_BITS-wide operand.

---
 rtl/x_400_mod_503_seq.sv | 74 +++++++
 tb/tb_x_400_mod_503_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/x_400_mod_503_seq.sv
// x_400_mod_503_seq: sequential X mod 503 reducer using one 9-bit Horner step per cycle
module x_400_mod_503_seq #(
    parameter int N_BITS = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] X,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        R,
    output logic              busy
);
    localparam int NCHUNK = (N_BITS + 8) / 9;
    localparam int PW     = 9 * NCHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_sh;
    logic [8:0]      r_acc;
    logic [CW-1:0]   r_cnt;
    logic [8:0]      r_r;
    logic [12:0]     w_v;
    logic [9:0]      w_f;
    logic [8:0]      w_acc;
    logic            w_accept;
    logic            w_last;

    assign w_v      = 13'd9 * {4'b0, r_acc} + {4'b0, r_sh[PW-1 -: 9]};
    assign w_f      = 10'd9 * {6'b0, w_v[12:9]} + {1'b0, w_v[8:0]};
    assign w_acc    = (w_f >= 10'd503) ? 9'(w_f - 10'd503) : w_f[8:0];
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == RUN) && (r_cnt == '0);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign R         = r_r;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_r   <= '0;
        end else if (w_accept) begin
            r_sh  <= PW'(X);
            r_acc <= '0;
            r_cnt <= CW'(NCHUNK - 1);
        end else if (r_state == RUN) begin
            r_sh  <= r_sh << 9;
            r_acc <= w_acc;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) r_r <= w_acc;
        end
    end
endmodule

// File: tb/tb_x_400_mod_503_seq.sv
// tb_x_400_mod_503_seq: directed and random self-checking bench for the mod-503 reducer
module tb_x_400_mod_503_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [399:0] X = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [8:0]   R;
    logic         busy;
    int           n_pass = 0;
    int           n_total = 0;

    x_400_mod_503_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X),
        .out_valid(out_valid), .out_ready(out_ready), .R(R), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int mod503(input logic [399:0] x);
        int r = 0;
        for (int i = 399; i >= 0; i--) r = (r * 2 + int'(x[i])) % 503;
        return r;
    endfunction

    function automatic logic [399:0] rand400();
        logic [415:0] t;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        return t[399:0];
    endfunction

    task automatic do_op(input logic [399:0] x, output logic [8:0] r, output int lat);
        int n = 0;
        while (!in_ready && n < 200) begin cyc(); n++; end
        in_valid = 1'b1;
        X = x;
        cyc();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin cyc(); lat++; end
        r = R;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_total++;
        if ({in_ready, out_valid, busy, R} !== {1'b1, 1'b0, 1'b0, 9'd0})
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b R=%0d want 1 0 0 0", in_ready, out_valid, busy, R);
        else n_pass++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_zero();
        logic [8:0] r;
        int lat;
        do_op('0, r, lat);
        n_total++;
        if (lat !== 45) $display("FAIL zero_latency: got %0d want 45", lat); else n_pass++;
        n_total++;
        if (r !== 9'd0) $display("FAIL zero_result: got %0d want 0", r); else n_pass++;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL zero_after: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_singles();
        logic [399:0] xs [6];
        logic [8:0]   es [6];
        logic [8:0]   r;
        int           lat;
        xs[0] = 400'd502;    es[0] = 9'd502;
        xs[1] = 400'd503;    es[1] = 9'd0;
        xs[2] = 400'd505;    es[2] = 9'd2;
        xs[3] = 400'd512;    es[3] = 9'd9;
        xs[4] = 400'd1 << 18; es[4] = 9'd81;
        xs[5] = 400'd1 << 27; es[5] = 9'd226;
        for (int i = 0; i < 6; i++) begin
            do_op(xs[i], r, lat);
            n_total++;
            if (r !== es[i]) $display("FAIL single_%0d: got %0d want %0d", i, r, es[i]); else n_pass++;
        end
    endtask

    task automatic test_hold();
        int n = 0;
        in_valid = 1'b1;
        X = 400'd505;
        cyc();
        while (!out_valid && n < 200) begin
            X = rand400();
            cyc();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            X = rand400();
            n_total++;
            if ({out_valid, in_ready, R} !== {1'b1, 1'b0, 9'd2})
                $display("FAIL hold_%0d: out_valid=%b in_ready=%b R=%0d want 1 0 2", i, out_valid, in_ready, R);
            else n_pass++;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, in_ready, R} !== {1'b0, 1'b1, 9'd2})
            $display("FAIL hold_release: out_valid=%b in_ready=%b R=%0d want 0 1 2", out_valid, in_ready, R);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        logic [8:0] r;
        int lat;
        in_valid = 1'b1;
        X = 400'd12345;
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_total++;
        if ({out_valid, in_ready, busy, R} !== {1'b0, 1'b1, 1'b0, 9'd0})
            $display("FAIL rst_mid: out_valid=%b in_ready=%b busy=%b R=%0d want 0 1 0 0", out_valid, in_ready, busy, R);
        else n_pass++;
        do_op(400'd503, r, lat);
        n_total++;
        if (r !== 9'd0 || lat !== 45) $display("FAIL rst_mid_next: R=%0d lat=%0d want 0 45", r, lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [399:0] q [$];
        int acc = 0;
        int got = 0;
        int errs = 0;
        int n = 0;
        while (got < 200 && n < 40000) begin
            in_valid = (acc < 200);
            X = rand400();
            out_ready = $urandom_range(0, 1) == 1;
            if (in_valid && in_ready) begin q.push_back(X); acc++; end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL b2b_extra: R=%0d with no pending operand", R);
                end else begin
                    logic [399:0] x = q.pop_front();
                    if (R !== 9'(mod503(x))) begin
                        errs++;
                        $display("FAIL b2b_%0d: got %0d want %0d", got, R, mod503(x));
                    end
                end
                got++;
            end
            cyc();
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if (errs != 0) $display("FAIL b2b_results: %0d bad results want 0", errs); else n_pass++;
        n_total++;
        if (got != 200 || q.size() != 0)
            $display("FAIL b2b_count: got %0d results, %0d pending, want 200 and 0", got, q.size());
        else n_pass++;
    endtask

    task automatic test_all_ones();
        logic [8:0] r;
        int lat;
        do_op('1, r, lat);
        n_total++;
        if (r !== 9'(mod503('1))) $display("FAIL all_ones: got %0d want %0d", r, mod503('1)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_singles();
        test_hold();
        test_rst_mid();
        test_back_to_back();
        test_all_ones();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
